// File: rtl/fsmc_master.sv
`default_nettype none
// ============================================================================
//  Module      : fsmc_master
//  Description : Multiplexed address/data FSMC-style bus master with
//                programmable address-setup, hold, data and turnaround phases.
//                Define FSMC_MASTER_STATS_EN for saturating transfer counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module fsmc_master #(
    parameter int ADDSET  = 2,
    parameter int ADDHLD  = 1,
    parameter int DATAST  = 4,
    parameter int BUSTURN = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [17:0] cmd_addr,
    input  logic [15:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        busy,
    inout  wire  [17:0] AD,
    output logic        NADV,
    output logic        NWE,
    output logic        NOE,
    output logic [15:0] wr_count,
    output logic [15:0] rd_count
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ADDR = 3'd1,
        HOLD = 3'd2,
        DATA = 3'd3,
        TURN = 3'd4
    } state_t;

    localparam logic [15:0] c_addset_last  = 16'(ADDSET - 1);
    localparam logic [15:0] c_addhld_last  = 16'(ADDHLD - 1);
    localparam logic [15:0] c_datast_last  = 16'(DATAST - 1);
    localparam logic [15:0] c_busturn_last = 16'(BUSTURN - 1);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        write_q, write_d;
    logic [17:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [15:0] rdata_q, rdata_d;
    logic        nadv_q, nadv_d;
    logic        nwe_q, nwe_d;
    logic        noe_q, noe_d;
    logic        ad_oe_q, ad_oe_d;
    logic [17:0] ad_out_q, ad_out_d;
    logic        w_data_last;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + 16'd1;
        write_d     = write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_valid_d = 1'b0;
        rdata_d     = rdata_q;
        w_data_last = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (cmd_valid) begin
                    state_d = ADDR;
                    write_d = cmd_write;
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                end
            end
            ADDR: if (cnt_q == c_addset_last) begin
                state_d = HOLD;
                cnt_d   = '0;
            end
            HOLD: if (cnt_q == c_addhld_last) begin
                state_d = DATA;
                cnt_d   = '0;
            end
            DATA: if (cnt_q == c_datast_last) begin
                w_data_last = 1'b1;
                cnt_d       = '0;
                state_d     = (BUSTURN == 0) ? IDLE : TURN;
                // Sample while NOE is still low; the strobe rises on this same edge.
                if (!write_q) begin
                    rsp_valid_d = 1'b1;
                    rdata_d     = AD[15:0];
                end
            end
            TURN: if (cnt_q == c_busturn_last) begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: state_d = IDLE;
        endcase

        // Pin values are decoded from the next state so they are pure flop outputs.
        nadv_d   = (state_d != ADDR);
        nwe_d    = !((state_d == DATA) && write_d);
        noe_d    = !((state_d == DATA) && !write_d);
        ad_oe_d  = (state_d == ADDR) || (state_d == HOLD) || ((state_d == DATA) && write_d);
        ad_out_d = (state_d == DATA) ? {2'b00, wdata_d} : addr_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
            nadv_q      <= 1'b1;
            nwe_q       <= 1'b1;
            noe_q       <= 1'b1;
            ad_oe_q     <= 1'b0;
            ad_out_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
            nadv_q      <= nadv_d;
            nwe_q       <= nwe_d;
            noe_q       <= noe_d;
            ad_oe_q     <= ad_oe_d;
            ad_out_q    <= ad_out_d;
        end
    end

    assign AD        = ad_oe_q ? ad_out_q : 18'bz;
    assign NADV      = nadv_q;
    assign NWE       = nwe_q;
    assign NOE       = noe_q;
    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_q;

`ifdef FSMC_MASTER_STATS_EN
    logic [15:0] wr_cnt_q, wr_cnt_d;
    logic [15:0] rd_cnt_q, rd_cnt_d;

    always_comb begin
        wr_cnt_d = wr_cnt_q;
        rd_cnt_d = rd_cnt_q;
        if (w_data_last && write_q && (wr_cnt_q != 16'hFFFF)) begin
            wr_cnt_d = wr_cnt_q + 16'd1;
        end
        if (w_data_last && !write_q && (rd_cnt_q != 16'hFFFF)) begin
            rd_cnt_d = rd_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
        end else begin
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
        end
    end

    assign wr_count = wr_cnt_q;
    assign rd_count = rd_cnt_q;
`else
    assign wr_count = '0;
    assign rd_count = '0;
`endif

endmodule
`default_nettype wire

// File: doc/fsmc_master.md
FSMC_MASTER -- requirements
Module: fsmc_master

Interface
REQ-001 Parameter ADDSET, default 2: NADV-low address-setup length in clk cycles, minimum 1.
REQ-002 Parameter ADDHLD, default 1: address-hold length after NADV rises, in clk cycles, minimum 1.
REQ-003 Parameter DATAST, default 4: NWE/NOE-low data-phase length in clk cycles, minimum 1.
REQ-004 Parameter BUSTURN, default 1: idle turnaround cycles after each access, minimum 0.
REQ-005 clk  in  1  single system clock; all logic on its rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 cmd_valid  in  1  command request.
REQ-008 cmd_ready  out  1  high when a command can be accepted.
REQ-009 cmd_write  in  1  1 = write, 0 = read.
REQ-010 cmd_addr  in  18  bus address.
REQ-011 cmd_wdata  in  16  write data.
REQ-012 rsp_valid  out  1  one-cycle pulse; read data valid.
REQ-013 rsp_rdata  out  16  captured read data.
REQ-014 busy  out  1  high while a transaction is in flight.
REQ-015 AD  inout  18  multiplexed address/data bus.
REQ-016 NADV  out  1  address valid, active low.
REQ-017 NWE  out  1  write enable, active low.
REQ-018 NOE  out  1  read enable, active low.
REQ-019 wr_count, rd_count  out  16 each  completed-transaction counters.

Function
REQ-020 The FSM SHALL have the states IDLE, ADDR, HOLD, DATA and TURN; busy = (state != IDLE); cmd_ready = (state == IDLE).
REQ-021 A command SHALL be accepted on the edge where cmd_valid and cmd_ready are both high; cmd_write, cmd_addr and cmd_wdata are latched on that edge; the next state is ADDR.
REQ-022 ADDR SHALL last ADDSET cycles with NADV=0, AD driven with the latched address, and NWE=NOE=1.
REQ-023 HOLD SHALL last ADDHLD cycles with NADV=1 and AD still driving the address.
REQ-024 During a DATA write, NWE=0 for DATAST cycles and AD = {2'b00, wdata}.
REQ-025 During a DATA read, NOE=0 for DATAST cycles and AD is high-Z for the whole phase.
REQ-026 A read SHALL sample AD[15:0] on the edge ending the last DATA cycle; rsp_valid SHALL be high for exactly the following cycle, with rsp_rdata equal to that sample.
REQ-027 rsp_rdata SHALL hold its value until the next read completes; writes never pulse rsp_valid.
REQ-028 TURN SHALL last BUSTURN cycles with all strobes high and AD high-Z, then the FSM returns to IDLE; if BUSTURN=0, DATA goes directly to IDLE.
REQ-029 NADV, NWE, NOE and the AD output-enable SHALL be registered outputs, glitch-free, and never low simultaneously in any pair.
REQ-030 AD SHALL be high-Z in IDLE.
REQ-031 cmd_valid while cmd_ready=0 SHALL be ignored; the command is not queued.
REQ-032 Total occupancy per access SHALL be 1 + ADDSET + ADDHLD + DATAST + BUSTURN cycles, from the accept edge to cmd_ready being high again.

Reset
REQ-033 While rst_n=0, the block SHALL immediately set: state=IDLE; NADV=NWE=NOE=1; AD high-Z; rsp_valid=0; rsp_rdata=0; busy=0; cmd_ready=1 after release; counters=0.
REQ-034 Reset asserted mid-transaction SHALL abort the transaction with no rsp_valid and no counter update.

Configuration
REQ-035 With FSMC_MASTER_STATS_EN defined:
- wr_count increments on each completed write, at the last DATA edge.
- rd_count increments on each completed read, at the last DATA edge.
- Both counters saturate at 16'hFFFF.
REQ-036 Without FSMC_MASTER_STATS_EN, wr_count and rd_count SHALL be constant 0 and no counter registers are synthesized.

Verification
REQ-037 Defaults; write addr 18'h00005, data 16'hA55A -> NADV low for 2 cycles with AD=00005; 1 hold cycle; NWE low for 4 cycles with AD=0A55A; 1 turn cycle; cmd_ready high 9 cycles after the accept edge.
REQ-038 Defaults; read addr 18'h10003 while the model drives 16'h1234 during NOE low -> AD high-Z during DATA; rsp_valid pulses once; rsp_rdata=16'h1234.
REQ-039 Back-to-back: cmd_valid held high for 3 commands -> accepts exactly 9 cycles apart; NWE/NOE never overlap NADV.
REQ-040 rst_n pulled low in the 2nd DATA cycle of a read -> strobes high and AD high-Z immediately; no rsp_valid; rd_count unchanged.
REQ-041 BUSTURN=0, ADDSET=1, DATAST=1 -> each access occupies 4 cycles; rsp_valid is still a single-cycle pulse.
REQ-042 With FSMC_MASTER_STATS_EN, 3 writes and 2 reads -> wr_count=3, rd_count=2; without the macro -> both stay 0.
